// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the 5-stage MIPS pipeline.
package pipeline_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, hold and flush (flush wins).
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc4In,
    input  logic [31:0] instrIn,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4 <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc4 <= pc4In;
            instr <= instrIn;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, imem handshake and IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter logic [31:0] PC_STEP = pipeline_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
);
    import pipeline_pkg::*;

    fetch_state_t state, stateNext;
    logic [31:0] pc, pcNext, fetchAddr, fetchAddrNext;
    logic [31:0] holdPc4, holdPc4Next, holdInstr, holdInstrNext;
    logic [31:0] target, pcPlus, ifidPc4In, ifidInstrIn;
    logic live, redirect, ready, ifidLoad, ifidFlush;

    assign redirect = branch_taken_i | jump_i;
    assign target = alignWord(branch_taken_i ? branch_target_i : jump_target_i);
    assign pcPlus = pc + PC_STEP;
    // live gates the first cycle after reset so the request starts on a clean edge
    assign ready = imem_ready_i & live;
    assign imem_req_o = live & (state != HOLD);
    assign imem_addr_o = fetchAddr;
    assign pc_o = pc;

    always_comb begin
        stateNext = state;
        pcNext = pc;
        fetchAddrNext = fetchAddr;
        holdPc4Next = holdPc4;
        holdInstrNext = holdInstr;
        ifidLoad = 1'b0;
        ifidFlush = 1'b0;
        ifidPc4In = holdPc4;
        ifidInstrIn = holdInstr;
        if (live) begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pcNext = target;
                        ifidFlush = 1'b1;
                        fetchAddrNext = ready ? target : fetchAddr;
                        stateNext = ready ? FETCH : DISCARD;
                    end else if (stall_i) begin
                        holdPc4Next = ready ? pcPlus : holdPc4;
                        holdInstrNext = ready ? imem_rdata_i : holdInstr;
                        stateNext = ready ? HOLD : FETCH;
                    end else if (ready) begin
                        ifidLoad = 1'b1;
                        ifidPc4In = pcPlus;
                        ifidInstrIn = imem_rdata_i;
                        pcNext = pcPlus;
                        fetchAddrNext = pcPlus;
                    end else begin
                        ifidFlush = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pcNext = target;
                        fetchAddrNext = target;
                        holdPc4Next = '0;
                        holdInstrNext = '0;
                        ifidFlush = 1'b1;
                        stateNext = FETCH;
                    end else if (!stall_i) begin
                        ifidLoad = 1'b1;
                        pcNext = pcPlus;
                        fetchAddrNext = pcPlus;
                        stateNext = FETCH;
                    end
                end
                DISCARD: begin
                    pcNext = redirect ? target : pc;
                    fetchAddrNext = ready ? pcNext : fetchAddr;
                    stateNext = ready ? FETCH : DISCARD;
                end
                default: stateNext = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            fetchAddr <= RESET_PC;
            holdPc4 <= '0;
            holdInstr <= '0;
            live <= 1'b0;
        end else begin
            state <= stateNext;
            pc <= pcNext;
            fetchAddr <= fetchAddrNext;
            holdPc4 <= holdPc4Next;
            holdInstr <= holdInstrNext;
            live <= 1'b1;
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) ifid (
        .clk(clk),
        .rst_n(rst_n),
        .load(ifidLoad),
        .flush(ifidFlush),
        .pc4In(ifidPc4In),
        .instrIn(ifidInstrIn),
        .pc4(ifid_pc4_o),
        .instr(ifid_instr_o),
        .valid(ifid_valid_o)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a word-indexed instruction memory model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n, stall, branch, jump, ready;
    logic [31:0] branchTarget, jumpTarget;
    logic req;
    logic [31:0] addr, rdata, pc, pc4, instr;
    logic valid;
    logic rst2_n, stall2, req2, valid2;
    logic [31:0] addr2, rdata2, pc2, pc4b, instr2;
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instrAt(input logic [31:0] a);
        return 32'h2000_0000 + ((a >> 2) + 32'd1) * 32'h0001_000A;
    endfunction

    assign rdata = instrAt(addr);
    assign rdata2 = instrAt(addr2);

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .branch_taken_i(branch), .branch_target_i(branchTarget),
        .jump_i(jump), .jump_target_i(jumpTarget),
        .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ready_i(ready),
        .pc_o(pc), .ifid_pc4_o(pc4), .ifid_instr_o(instr), .ifid_valid_o(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .stall_i(stall2),
        .branch_taken_i(1'b0), .branch_target_i(32'h0),
        .jump_i(1'b0), .jump_target_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2), .imem_ready_i(1'b1),
        .pc_o(pc2), .ifid_pc4_o(pc4b), .ifid_instr_o(instr2), .ifid_valid_o(valid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkIfid(input string tag, input logic [31:0] p4, input logic [31:0] ins, input logic v);
        chk({tag, ".pc4"}, pc4, p4);
        chk({tag, ".instr"}, instr, ins);
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; stall2 = 1'b0;
        branch = 1'b0; jump = 1'b0; ready = 1'b1;
        branchTarget = '0; jumpTarget = '0;
        #12;
        chk("rst.pc", pc, 32'h0);
        chk("rst.req", {31'b0, req}, 32'h0);
        chkIfid("rst", 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("live.req", {31'b0, req}, 32'h1);
        chk("live.addr", addr, 32'h0);
        chk("live.valid", {31'b0, valid}, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("seq.pc", pc, 32'(4 * k));
            chkIfid("seq", 32'(4 * k), instrAt(32'(4 * (k - 1))), 1'b1);
        end
        stall = 1'b1;
        step();
        chk("stall1.pc", pc, 32'd16);
        chk("stall1.req", {31'b0, req}, 32'h0);
        chkIfid("stall1", 32'd16, instrAt(32'd12), 1'b1);
        step();
        chk("stall2.pc", pc, 32'd16);
        chk("stall2.req", {31'b0, req}, 32'h0);
        stall = 1'b0;
        step();
        chk("unstall.pc", pc, 32'd20);
        chk("unstall.req", {31'b0, req}, 32'h1);
        chkIfid("unstall", 32'd20, instrAt(32'd16), 1'b1);
        branch = 1'b1; branchTarget = 32'h40;
        step();
        chk("br.pc", pc, 32'h40);
        chk("br.addr", addr, 32'h40);
        chkIfid("br", 32'd20, 32'h0, 1'b0);
        branch = 1'b0;
        step();
        chk("br.next.pc", pc, 32'h44);
        chkIfid("br.next", 32'h44, instrAt(32'h40), 1'b1);
        ready = 1'b0; jump = 1'b1; jumpTarget = 32'h100;
        step();
        chk("jmp.pc", pc, 32'h100);
        chk("jmp.addr", addr, 32'h44);
        chk("jmp.req", {31'b0, req}, 32'h1);
        chk("jmp.valid", {31'b0, valid}, 32'h0);
        jump = 1'b0;
        step();
        chk("disc.addr", addr, 32'h44);
        chk("disc.valid", {31'b0, valid}, 32'h0);
        ready = 1'b1;
        step();
        chk("disc.done.addr", addr, 32'h100);
        chk("disc.done.pc", pc, 32'h100);
        chk("disc.done.valid", {31'b0, valid}, 32'h0);
        step();
        chk("jmp.fetch.pc", pc, 32'h104);
        chkIfid("jmp.fetch", 32'h104, instrAt(32'h100), 1'b1);
        ready = 1'b0;
        step();
        chk("bubble.pc", pc, 32'h104);
        chkIfid("bubble", 32'h104, 32'h0, 1'b0);
        ready = 1'b1;
        branch = 1'b1; branchTarget = 32'h80; jump = 1'b1; jumpTarget = 32'h200;
        step();
        chk("prio.pc", pc, 32'h80);
        jump = 1'b0; branchTarget = 32'h83;
        step();
        chk("align.pc", pc, 32'h80);
        chk("align.addr", addr, 32'h80);
        branch = 1'b0;
        step();
        chk("align.next.pc", pc, 32'h84);
        chkIfid("align.next", 32'h84, instrAt(32'h80), 1'b1);
        stall = 1'b1;
        step();
        chk("hold.req", {31'b0, req}, 32'h0);
        branch = 1'b1; branchTarget = 32'h300;
        step();
        chk("holdredir.pc", pc, 32'h300);
        chk("holdredir.req", {31'b0, req}, 32'h1);
        chk("holdredir.valid", {31'b0, valid}, 32'h0);
        branch = 1'b0; stall = 1'b0;
        step();
        chk("holdredir.next.pc", pc, 32'h304);
        chkIfid("holdredir.next", 32'h304, instrAt(32'h300), 1'b1);
        rst2_n = 1'b1;
        step();
        chk("wrap.live.pc", pc2, 32'hFFFF_FFFC);
        step();
        chk("wrap.pc", pc2, 32'h0);
        chk("wrap.pc4", pc4b, 32'h0);
        chk("wrap.instr", instr2, instrAt(32'hFFFF_FFFC));
        chk("wrap.valid", {31'b0, valid2}, 32'h1);
        stall2 = 1'b1;
        step();
        chk("wrap.stall.req", {31'b0, req2}, 32'h0);
        chk("wrap.stall.valid", {31'b0, valid2}, 32'h1);
        #3 rst2_n = 1'b0;
        #1;
        chk("arst.valid", {31'b0, valid2}, 32'h0);
        chk("arst.pc", pc2, 32'hFFFF_FFFC);
        chk("arst.req", {31'b0, req2}, 32'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst1.pc", pc, 32'h0);
        chk("arst1.valid", {31'b0, valid}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
